// File: rtl/instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_prefetch
//  Description : Sequential instruction prefetcher in front of a one-cycle
//                latency flash. Issues word-aligned reads under a credit
//                rule, buffers {pc, data} in a small FIFO and hands words to
//                decode over valid/ready. A redirect flushes buffered and
//                in-flight fetches and restarts at a new PC.
//                Optional macro PREFETCH_BYPASS_EN forwards a flash response
//                straight to decode when the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] flash_addr,
    output logic        flash_lenable,
    input  logic [31:0] flash_ldata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic [31:0]        r_pc_mem   [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_fifo_nonempty;
    logic               w_resp;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_pop;
    logic [c_cnt_w:0]   w_occ;
    logic               w_issue;
`ifdef PREFETCH_BYPASS_EN
    logic               w_bypass;
`endif

    // The low two redirect bits are defined as ignored; fold them away here.
    logic w_unused_redirect_lsbs;
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // Decode-side view, push/pop decisions and the issue credit check.
    always_comb begin
        w_fifo_nonempty = (r_count != '0);
        // A response landing in a redirect cycle belongs to the old stream.
        w_resp          = r_inflight && !redirect_valid;
`ifdef PREFETCH_BYPASS_EN
        w_bypass        = !w_fifo_nonempty && w_resp;
        instr_valid     = rst && (w_fifo_nonempty || w_resp);
        instr_data      = w_bypass ? flash_ldata   : r_data_mem[r_rd_ptr];
        instr_pc        = w_bypass ? r_inflight_pc : r_pc_mem[r_rd_ptr];
        // A bypassed word that decode takes immediately never enters the FIFO.
        w_push          = rst && w_resp && !(w_bypass && instr_ready);
`else
        instr_valid     = rst && w_fifo_nonempty;
        instr_data      = r_data_mem[r_rd_ptr];
        instr_pc        = r_pc_mem[r_rd_ptr];
        w_push          = rst && w_resp;
`endif
        w_pop           = instr_valid && instr_ready;
        w_fifo_pop      = w_pop && w_fifo_nonempty;
        // Slots committed at the end of this cycle if nothing new is issued;
        // issuing only while this is below DEPTH means a push never overflows.
        w_occ           = {1'b0, r_count}
                        + (c_cnt_w + 1)'(r_inflight)
                        - (c_cnt_w + 1)'(w_pop);
        w_issue         = rst && !redirect_valid && (w_occ < c_depth_ext);
        flash_lenable   = w_issue;
        flash_addr      = r_fetch_pc;
    end

    // Fetch pointer, in-flight tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else if (redirect_valid) begin
            // Any word popped this cycle is already decode's; the rest is stale.
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_fifo_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_inflight_pc;
            r_data_mem[r_wr_ptr] <= flash_ldata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_prefetch
//  Description : Scoreboard bench for instr_prefetch. Stimulus pushes the
//                expected fetch addresses and decode PCs into queues; a
//                monitor pops and compares on every issue and every accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
`ifdef PREFETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] flash_addr;
    logic        flash_lenable;
    logic [31:0] flash_ldata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    instr_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flash_addr     (flash_addr),
        .flash_lenable  (flash_lenable),
        .flash_ldata    (flash_ldata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Flash content is a fixed function of the word address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // One-cycle-latency flash model.
    always @(posedge clk) begin
        flash_ldata <= flash_lenable ? word_of(flash_addr) : 32'hDEAD_BEEF;
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_pc_q   [$];

    int cyc            = 0;
    int issues_total   = 0;
    int accepted_total = 0;
    int issued_os      = 0;
    int accepted_os    = 0;
    int arm_seq        = 0;
    int seen_arm       = 0;
    int first_issue    = -1;
    int first_valid    = -1;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc   = '0;
    logic [31:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_addr_q.delete();
        exp_pc_q.delete();
    endtask

    // Sequential stream of 64 words starting at start, for both issue and decode.
    task automatic expect_seq(input logic [31:0] start);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < 64; i++) begin
            exp_addr_q.push_back(a);
            exp_pc_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b0;
        instr_ready    = rdy;
        redirect_valid = 1'b0;
        clear_q();
        repeat (3) tick();
        rst = 1'b1;
        expect_seq(RESET_PC);
        arm_seq++;
    endtask

    // Monitor: samples everything on the falling edge.
    task automatic monitor_loop();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (arm_seq != seen_arm) begin
                seen_arm    = arm_seq;
                first_issue = -1;
                first_valid = -1;
            end
            if (!rst) begin
                check("reset_lenable", 32'(flash_lenable), 32'd0);
                check("reset_valid", 32'(instr_valid), 32'd0);
                issued_os   = 0;
                accepted_os = 0;
                prev_hold   = 1'b0;
            end else begin
                check("no_overflow", 32'(issued_os - accepted_os <= DEPTH), 32'd1);
                if (redirect_valid)
                    check("redirect_no_issue", 32'(flash_lenable), 32'd0);
                if (prev_hold) begin
                    check("hold_valid", 32'(instr_valid), 32'd1);
                    check("hold_pc", instr_pc, prev_pc);
                    check("hold_data", instr_data, prev_data);
                end
                if (flash_lenable) begin
                    if (first_issue < 0) first_issue = cyc;
                    if (exp_addr_q.size() == 0) begin
                        check("issue_unexpected", flash_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_addr_q.pop_front();
                        check("issue_addr", flash_addr, e);
                    end
                    issues_total++;
                    issued_os++;
                end
                if (instr_valid && first_issue >= 0 && first_valid < 0) begin
                    first_valid = cyc;
                    check("first_valid_latency", 32'(first_valid - first_issue), 32'(LAT));
                end
                if (instr_valid && instr_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        check("accept_unexpected", instr_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_pc_q.pop_front();
                        check("accept_pc", instr_pc, e);
                        check("accept_data", instr_data, word_of(e));
                    end
                    accepted_total++;
                    accepted_os++;
                end
                prev_hold = instr_valid && !instr_ready && !redirect_valid;
                prev_pc   = instr_pc;
                prev_data = instr_data;
                if (redirect_valid) begin
                    issued_os   = 0;
                    accepted_os = 0;
                end
            end
        end
    endtask

    // Directed stimulus.
    initial begin
        int   snap;
        int   r_cyc;
        logic found;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        fork
            monitor_loop();
        join_none

        // Reset release, streaming with decode always ready.
        do_reset(1'b1);
        snap = accepted_total;
        repeat (10) tick();
        check("stream_accepts", 32'(accepted_total - snap), 32'(10 - LAT));

        // Backpressure from reset: FIFO fills, issues stop, head is RESET_PC.
        do_reset(1'b0);
        snap = issues_total;
        repeat (10) tick();
        check("bp_issue_count", 32'(issues_total - snap), 32'(DEPTH));
        check("bp_head_valid", 32'(instr_valid), 32'd1);
        check("bp_head_pc", instr_pc, RESET_PC);
        instr_ready = 1'b1;
        snap = accepted_total;
        repeat (8) tick();
        check("bp_drain_no_gaps", 32'(accepted_total - snap), 32'd8);

        // Redirect to 0x203 the cycle after the 0x108 issue.
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (flash_lenable && flash_addr == 32'h0000_0108) found = 1'b1;
        end
        check("wait_issue_108", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        r_cyc          = cyc + 1;
        tick();
        redirect_valid = 1'b0;
        clear_q();
        expect_seq(32'h0000_0200);
        arm_seq++;
        snap = accepted_total;
        repeat (8) tick();
        check("redir_first_issue_cycle", 32'(first_issue), 32'(r_cyc + 1));
        check("redir_accepts", 32'(accepted_total - snap), 32'(8 - LAT));

        // Wrap of the fetch address across 2^32.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        clear_q();
        expect_seq(32'hFFFF_FFF8);
        arm_seq++;
        snap = accepted_total;
        repeat (8) tick();
        check("wrap_accepts", 32'(accepted_total - snap), 32'(8 - LAT));

        // Reset asserted while a request is in flight.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (flash_lenable) found = 1'b1;
        end
        check("wait_inflight", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        tick();
        rst = 1'b1;
        expect_seq(RESET_PC);
        arm_seq++;
        check("no_linger_valid", 32'(instr_valid), 32'd0);
        check("restart_addr", flash_addr, RESET_PC);
        snap = accepted_total;
        repeat (8) tick();
        check("restart_accepts", 32'(accepted_total - snap), 32'(8 - LAT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch unit sitting directly upstream of the on-chip flash instruction memory. It generates sequential word-aligned fetch addresses and read enables toward the flash. It captures the flash's one-cycle-latency read data into a small FIFO tagged with its PC, and presents instructions to decode over a valid/ready handshake. A redirect input (branch/jump/trap) flushes buffered and in-flight fetches and restarts fetching at a new PC.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- flash_addr  out  32  byte address to flash; bits [1:0] always 0.
- flash_lenable  out  1  read request to flash, sampled by flash on posedge.
- flash_ldata  in  32  flash read data, valid the cycle after the request.
- redirect_valid  in  1  one-cycle pulse; restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  head entry available to decode.
- instr_data  out  32  instruction word at the head.
- instr_pc  out  32  PC of instr_data.
- instr_ready  in  1  decode accepts the head this cycle.

## Operation
- State:
  - fetch_pc: next address to request.
  - inflight: 1 bit, request issued last cycle.
  - inflight_pc.
  - FIFO of {pc, data}, DEPTH entries, with count.
- Pop: instr_valid && instr_ready.
- Issue condition, combinational: rst==1 && !redirect_valid && (count + inflight − pop) < DEPTH.
- When the issue condition holds:
  - flash_lenable=1 and flash_addr=fetch_pc.
  - On the clock edge: inflight←1, inflight_pc←fetch_pc, fetch_pc←fetch_pc+4.
  - Otherwise inflight←0 and flash_lenable=0. flash_addr still shows fetch_pc.
- Response: when inflight==1 and no redirect this cycle, push {inflight_pc, flash_ldata}.
- Push and pop may occur in the same cycle, including when count==DEPTH. Count is unchanged in that case.
- The credit rule guarantees no push into a full FIFO. The bench asserts that overflow never happens.
- Redirect (redirect_valid=1):
  - count←0 and inflight←0. The in-flight response present this cycle is discarded.
  - fetch_pc←{redirect_pc[31:2],2'b00}.
  - No issue in the redirect cycle.
  - A pop in the same cycle still completes: decode owns that instruction.
- fetch_pc increment wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- instr_data and instr_pc are don't-care while instr_valid==0. They must hold stable while instr_valid==1 && instr_ready==0.

## Timing
- Reset, during rst==0 and on the edge that samples it:
  - fetch_pc←RESET_PC, count←0, inflight←0.
  - flash_lenable=0 and instr_valid=0 for the whole cycle.
- Issue in cycle n. flash_ldata is valid in cycle n+1, when the push happens. Without bypass, instr_valid=1 in cycle n+2.
- Steady state with instr_ready held high: one instruction per cycle, no bubbles, DEPTH ≥ 2.
- After redirect in cycle r:
  - First issue at the new PC in cycle r+1.
  - First instr_valid in cycle r+3, or r+2 with bypass.
- Redirect arriving in the same cycle as a flash response: redirect wins and the response is dropped.
- Reset in the middle of an in-flight request: the response is dropped. There is no lingering valid.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When count==0 and a non-dropped response is present, instr_valid=1 in that same cycle, with instr_data=flash_ldata and instr_pc=inflight_pc.
  - If instr_ready==1 that cycle, the word is consumed and not pushed. Otherwise it is pushed normally.
  - Issue credit treats this bypass pop as a pop.
- PREFETCH_BYPASS_EN undefined: instr_valid is driven only by count != 0. Fetch-to-decode latency is 2 cycles.

## Test plan
- Reset release with RESET_PC=32'h100 and instr_ready=1:
  - flash_addr sequence is 0x100, 0x104, 0x108, …
  - instr_pc is the same sequence with matching flash words.
  - First instr_valid arrives 2 cycles after the first issue, or 1 cycle with bypass.
- Backpressure with instr_ready=0 for 10 cycles: issues stop with count==DEPTH and no overflow. The head stays 0x100. On release, 0x100…0x10C drain in order without gaps.
- Redirect to 32'h203 one cycle after an issue at 0x108:
  - The 0x108 response is dropped and the FIFO is emptied.
  - The next issue is 0x200.
  - The next instr_pc seen by decode is 0x200.
- Redirect while instr_valid && instr_ready: the popped word is accepted, and no stale PC appears afterward.
- Wrap: redirect to 32'hFFFF_FFF8 gives issues at FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with one request in flight: instr_valid=0 next cycle. After release, fetch restarts at RESET_PC.
